// File: rtl/load_store_unit_pkg.sv
// RV32I opcode encodings and load/store unit state definitions.
// Shared by the load/store unit and its load extension datapath.
package rv32i_opcodes;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load data extraction: picks the byte/halfword lane and extends it.
// Unknown funct3 encodings fall through to a full-word load.
module load_extend
    import rv32i_opcodes::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    output logic [XLEN-1:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select lane data, then extend according to the access type.
    always_comb begin
        unique case (lane)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LB:      ext = {{24{byte_sel[7]}}, byte_sel};
            LBU:     ext = {24'd0, byte_sel};
            LH:      ext = {{16{half_sel[15]}}, half_sel};
            LHU:     ext = {16'd0, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: req/ack data-memory transaction with timeout.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module load_store_unit
    import rv32i_opcodes::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_load,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic             busy,
    output logic             done,
    output logic             err,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic             misaligned,
`endif
    output logic [WIDTH-1:0] mem_rd_data,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [3:0]       dmem_be,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    if (WIDTH != 32) begin : g_width_check
        $error("load_store_unit supports WIDTH=32 only");
    end

    lsu_state_t       state_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [2:0]       f3_q;
    logic [1:0]       lane_q;
    logic             load_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] rd_q;
    logic             req_q;
    logic             we_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [3:0]       be_q;
    logic [3:0]       be_d;
    logic [WIDTH-1:0] wdata_d;
    logic [WIDTH-1:0] ext_d;
    logic             accept;
    logic             trap_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic             mis_q;
`endif

    load_extend u_load_extend (
        .rdata  (dmem_rdata),
        .funct3 (f3_q),
        .lane   (lane_q),
        .ext    (ext_d)
    );

    assign accept = start && (is_load || is_store);
    assign cnt_d  = cnt_q + 1'b1;

    // Byte enables and lane-replicated write data for the incoming request.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = store_data;
        if (!is_load) begin
            case (funct3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << addr[1:0];
                    wdata_d = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be_d    = 4'b0011 << {addr[1], 1'b0};
                    wdata_d = {2{store_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Misalignment detection; without the trap, low bits are just ignored.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        trap_d = ((funct3[1:0] == 2'b01) && addr[0])
              || (funct3[1] && (addr[1:0] != 2'b00));
`else
        trap_d = 1'b0;
`endif
    end

    // Transaction FSM with registered memory-port and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            lane_q  <= '0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q  <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        f3_q   <= funct3;
                        lane_q <= addr[1:0];
                        load_q <= is_load;
                        cnt_q  <= '0;
                        if (trap_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                            mis_q   <= 1'b1;
`endif
                        end else begin
                            state_q <= WAIT;
                            req_q   <= 1'b1;
                            we_q    <= !is_load;
                            addr_q  <= {addr[WIDTH-1:2], 2'b00};
                            wdata_q <= wdata_d;
                            be_q    <= be_d;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                        if (load_q) begin
                            rd_q <= ext_d;
                        end
                    end else if (cnt_d == CW'(MAX_WAIT)) begin
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign mem_rd_data = rd_q;
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign dmem_be     = be_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned  = mis_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: scoreboard of expected completions
// plus a standalone sweep of the load_extend datapath.
module tb_load_store_unit;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] mem_rd_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    logic [31:0] le_rd;
    logic [2:0]  le_f3;
    logic [1:0]  le_ln;
    logic [31:0] le_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rd = 32'h0;

    typedef struct {
        int          cyc;
        int          nreq;
        logic        err;
        logic        mis;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    load_store_unit #(
        .WIDTH    (32),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_load     (is_load),
        .is_store    (is_store),
        .funct3      (funct3),
        .addr        (addr),
        .store_data  (store_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
`ifdef LSU_MISALIGN_TRAP_EN
        .misaligned  (misaligned),
`endif
        .mem_rd_data (mem_rd_data),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata)
    );

    load_extend u_ext (
        .rdata  (le_rd),
        .funct3 (le_f3),
        .lane   (le_ln),
        .ext    (le_out)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [31:0] w,
                                            input logic [2:0] f3,
                                            input logic [1:0] ln);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * ln));
        h = ln[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic ld,
                                          input logic [2:0] f3,
                                          input logic [1:0] a);
        if (ld) return 4'hF;
        case (f3[1:0])
            2'b00:   return 4'(1 << a);
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wd(input logic [2:0] f3,
                                           input logic [31:0] sd);
        case (f3[1:0])
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    // One request; k = ack cycle (0 = never), poke = extra start in WAIT.
    task automatic run_op(input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rdv,
                          input int k, input bit poke);
        exp_t e;
        exp_t g;
        int   c;
        int   nreq;
        bit   seen;
        bit   mis;
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = ((f3[1:0] == 2'b01) && a[0]) || (f3[1] && (a[1:0] != 2'b00));
`endif
        e.mis  = mis;
        e.err  = !mis && (k == 0);
        e.cyc  = mis ? 1 : ((k == 0) ? MAXW + 1 : k + 1);
        e.nreq = mis ? 0 : ((k == 0) ? MAXW : k);
        if (ld && !mis && k != 0) exp_rd = ref_ext(rdv, f3, a[1:0]);
        e.rd = exp_rd;
        sb.push_back(e);

        @(posedge clk); #1;
        start = 1'b1; is_load = ld; is_store = st;
        funct3 = f3; addr = a; store_data = sd;
        c = 0; nreq = 0; seen = 1'b0;
        while (!seen && c < 300) begin
            @(posedge clk); #1;
            c++;
            start = poke && (c == 2);
            dmem_ack = 1'b0;
            if (dmem_req) nreq++;
            if (c == 1 && !mis) begin
                chk("busy_c1", 32'(busy), 32'd1);
                chk("addr_c1", dmem_addr, {a[31:2], 2'b00});
                chk("we_c1", 32'(dmem_we), 32'(!ld));
                chk("be_c1", 32'(dmem_be), 32'(ref_be(ld, f3, a[1:0])));
                if (!ld) chk("wdata_c1", dmem_wdata, ref_wd(f3, sd));
            end
            if (done) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    g = sb.pop_front();
                    chk("done_cyc", 32'(c), 32'(g.cyc));
                    chk("req_cycles", 32'(nreq), 32'(g.nreq));
                    chk("err", 32'(err), 32'(g.err));
                    chk("rd_data", mem_rd_data, g.rd);
                    chk("busy_done", 32'(busy), 32'd1);
`ifdef LSU_MISALIGN_TRAP_EN
                    chk("misaligned", 32'(misaligned), 32'(g.mis));
`endif
                end
            end else if (c == k) begin
                dmem_ack = 1'b1;
                dmem_rdata = rdv;
            end
        end
        start = 1'b0;
        dmem_ack = 1'b0;
        if (!seen) begin
            chk("done_seen", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
            chk("done_pulse", 32'(done), 32'd0);
            chk("idle_after", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = 3'b0; addr = 32'h0; store_data = 32'h0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        le_rd = 32'h0; le_f3 = 3'b0; le_ln = 2'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_be", 32'(dmem_be), 32'h0);
        chk("rst_rd", mem_rd_data, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("rst_mis", 32'(misaligned), 32'd0);
`endif

        // LBU, LH, SB, SH, LB, LHU, both-flags load
        run_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 2, 0);
        run_op(1, 0, 3'b001, 32'h202, 32'h0, 32'h8001_7FFF, 1, 0);
        run_op(0, 1, 3'b000, 32'h301, 32'hAB, 32'h0, 2, 0);
        run_op(0, 1, 3'b001, 32'h302, 32'h1234_CDEF, 32'h0, 3, 0);
        run_op(1, 0, 3'b000, 32'h011, 32'h0, 32'h0000_8000, 1, 0);
        run_op(1, 0, 3'b101, 32'h020, 32'h0, 32'h0000_9000, 2, 0);
        run_op(1, 1, 3'b010, 32'h030, 32'h5555_5555, 32'hCAFE_F00D, 1, 0);
        run_op(0, 1, 3'b010, 32'h040, 32'h0BAD_BEEF, 32'h0, 1, 0);

        // timeout with a second start during WAIT
        run_op(1, 0, 3'b010, 32'h500, 32'h0, 32'h0, 0, 1);

        // start with neither flag is ignored
        @(posedge clk); #1;
        start = 1'b1; is_load = 1'b0; is_store = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("noflag_busy", 32'(busy), 32'd0);
        chk("noflag_req", 32'(dmem_req), 32'd0);

        // reset while in WAIT
        @(posedge clk); #1;
        start = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h600;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rstw_req_pre", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd = 32'h0;
        chk("rstw_req", 32'(dmem_req), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("rstw_done2", 32'(done), 32'd0);

        run_op(1, 0, 3'b010, 32'h400, 32'h0, 32'hDEAD_BEEF, 3, 0);
        run_op(1, 0, 3'b010, 32'h402, 32'h0, 32'h1234_5678, 1, 0);
        run_op(1, 0, 3'b001, 32'h203, 32'h0, 32'h8765_4321, 1, 0);

        // standalone load_extend sweep
        for (int f = 0; f < 8; f++) begin
            for (int l = 0; l < 4; l++) begin
                for (int d = 0; d < 2; d++) begin
                    le_f3 = 3'(f);
                    le_ln = 2'(l);
                    le_rd = (d == 0) ? 32'h807F_FF01 : $urandom;
                    #1;
                    chk("load_extend", le_out, ref_ext(le_rd, le_f3, le_ln));
                end
            end
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- RV32I data-memory access stage. Takes a load/store request from execute (address = ALU result, data = rs2) and runs a req/ack transaction on the data-memory port.
- For loads, byte-lane extracts and sign/zero-extends the returned word into mem_rd_data, which feeds the register-file write-data select. Stalls the pipeline via busy while a transaction is in flight.

Parameters:
- WIDTH, 32, data/address width; only 32 supported (elaborate-time assertion).
- MAX_WAIT, 255, cycles to wait for dmem_ack before aborting with err; counter width $clog2(MAX_WAIT+1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request strobe from execute; sampled only in IDLE.
- is_load  input  1  request is a load.
- is_store  input  1  request is a store.
- funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- addr  input  WIDTH  effective byte address.
- store_data  input  WIDTH  rs2 value.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse with done on timeout.
- mem_rd_data  output  WIDTH  extended load result; held until next load done.
- dmem_req  output  1  memory request, held until ack.
- dmem_we  output  1  write enable.
- dmem_addr  output  WIDTH  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  output  WIDTH  lane-replicated store data.
- dmem_be  output  4  byte enables.
- dmem_ack  input  1  memory completion; valid only while dmem_req high.
- dmem_rdata  input  WIDTH  read word, valid with dmem_ack.

Behaviour:
- Reset: state IDLE; busy, done, err, dmem_req, dmem_we = 0; dmem_addr, dmem_wdata, mem_rd_data = 0; dmem_be = 0; wait counter = 0. Reset mid-transaction drops dmem_req the next cycle with no done.
- FSM IDLE -> WAIT -> DONE -> IDLE.
- IDLE: start && (is_load || is_store) latches funct3 and addr[1:0]; registers dmem_addr/we/wdata/be; sets dmem_req; goes to WAIT. Both flags set is treated as a load. Neither flag set, or start while busy, is ignored.
- WAIT: dmem_req and all dmem_* stay stable. Counter increments each cycle.
  - On dmem_ack: drop req; for loads, register extended data into mem_rd_data; go to DONE.
  - Counter reaching MAX_WAIT with no ack: drop req, set err; go to DONE; mem_rd_data unchanged.
- DONE: done=1 (err=1 on timeout) for exactly one cycle, then IDLE. A new start is accepted the following cycle.
- Latency: start at cycle 0, dmem_req from cycle 1, ack in cycle k, done in cycle k+1. Minimum 3 cycles with ack at cycle 1.
- Load extract, lane = latched addr[1:0]:
  - LB/LBU: byte lane, sign/zero-extended.
  - LH/LHU: halfword at addr[1], sign/zero-extended.
  - LW: full word.
  - funct3 011/110/111 treated as LW.
- Store:
  - SB: wdata = 4x byte, be = 4'b0001<<addr[1:0].
  - SH: wdata = 2x half, be = 4'b0011<<{addr[1],1'b0}.
  - SW: be = 4'b1111.
  - funct3[1]=1 treated as SW.
- Loads drive be = 4'b1111.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: adds output port misaligned (1 bit, reset 0). In IDLE, start with halfword and addr[0]=1, or word and addr[1:0]!=0, skips WAIT and goes straight to DONE. Raises done and misaligned together for one cycle; no dmem_req; mem_rd_data unchanged.
- Undefined: port absent; low address bits are truncated to natural alignment (half uses addr[1], word uses 00) and the access proceeds normally.

Decomposition:
- Package rv32i_opcodes gets:
  - load_funct3_t enum (LB, LH, LW, LBU, LHU) and store_funct3_t enum (SB, SH, SW);
  - lsu_state_t enum (IDLE, WAIT, DONE).
- One combinational sub-module, load_extend: inputs rdata, funct3, lane; outputs the extended word. Verified standalone.

Test Plan:
- LBU addr=0x103, dmem_rdata=0x80FF_1234, ack at cycle 2 -> dmem_addr=0x100, be=4'b1111, done at cycle 3, mem_rd_data=0x0000_0080.
- LH addr=0x202, rdata=0x8001_7FFF, ack at cycle 1 -> mem_rd_data=0xFFFF_8001, done at cycle 2, busy high cycles 1-2.
- SB addr=0x301, store_data=0x0000_00AB -> dmem_we=1, dmem_wdata=0xABAB_ABAB, dmem_be=4'b0010; done pulse after ack; mem_rd_data unchanged.
- Load with ack never asserted, MAX_WAIT=4 -> dmem_req high 4 cycles, then done=err=1 for one cycle; second start during WAIT ignored.
- rst asserted in WAIT -> next cycle dmem_req=0, busy=0, no done; a subsequent LW completes normally.
- LW addr=0x402 with LSU_MISALIGN_TRAP_EN -> no dmem_req, done=misaligned=1 at cycle 1; without macro -> dmem_addr=0x400, normal LW.
